// File: rtl/riscv_alu_pkg.sv
// Shared ALUctl encodings and controller state type for the sequential RISC-V ALU.
// State MUL exists only when RISCV_ALU_MUL_EN is defined.
package riscv_alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SLL  = 4'd3;
    localparam logic [3:0] ALU_SRL  = 4'd4;
    localparam logic [3:0] ALU_SRA  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_XOR  = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;
    localparam logic [3:0] ALU_NOR  = 4'd12;

`ifdef RISCV_ALU_MUL_EN
    typedef enum logic {ST_IDLE, ST_MUL} state_t;
`else
    typedef enum logic {ST_IDLE} state_t;
`endif

endpackage

// File: rtl/riscv_alu_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low XLEN bits kept.
// done and product are combinational so the caller can load the result on the last iteration edge.
module riscv_alu_mul #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic            running;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;

    // Value the accumulator takes at this edge; on the final iteration it is the result.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = running && (count == LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            running <= 1'b0;
            count   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= '0;
            mcand   <= a;
            mplier  <= b;
            acc     <= '0;
        end else if (running) begin
            acc     <= product;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            count   <= count + 1'b1;
            if (done)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/riscv_alu_seq.sv
// Sequential RISC-V ALU with valid/ready handshake on both sides and registered result.
// Define RISCV_ALU_MUL_EN to build the iterative multiplier (ALUctl=10); otherwise MUL yields 0.
module riscv_alu_seq
    import riscv_alu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ALUctl,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALUout,
    output logic            Zero,
    output logic            busy
);

    localparam int unsigned SW = $clog2(XLEN);

    state_t          state;
    logic            accept;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] result;

    assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign Zero     = (ALUout == '0);
    assign shamt    = B[SW-1:0];

    always_comb begin
        result = '0;
        case (ALUctl)
            ALU_AND:  result = A & B;
            ALU_OR:   result = A | B;
            ALU_ADD:  result = A + B;
            ALU_SLL:  result = A << shamt;
            ALU_SRL:  result = A >> shamt;
            ALU_SRA:  result = $signed(A) >>> shamt;
            ALU_SUB:  result = A - B;
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (A < B)};
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_XOR:  result = A ^ B;
            ALU_NOR:  result = ~(A | B);
            default:  result = '0;
        endcase
    end

`ifdef RISCV_ALU_MUL_EN
    logic            mul_start;
    logic            mul_done;
    logic [XLEN-1:0] mul_product;

    assign mul_start = accept && (ALUctl == ALU_MUL);
    assign busy      = (state == ST_MUL);

    riscv_alu_mul #(.XLEN(XLEN)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign busy = 1'b0;
`endif

    // A consumed result drops out_valid unless a new result loads at the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            ALUout    <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
`ifdef RISCV_ALU_MUL_EN
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (ALUctl == ALU_MUL) begin
                            state <= ST_MUL;
                        end else begin
                            ALUout    <= result;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        ALUout    <= mul_product;
                        out_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
`else
            if (accept) begin
                ALUout    <= result;
                out_valid <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_riscv_alu_seq.sv
// Scoreboard bench for riscv_alu_seq (XLEN=64): directed vectors, decoupled result monitor.
// Follows RISCV_ALU_MUL_EN so it matches whichever build of the design is compiled.
module tb_riscv_alu_seq;

    localparam int unsigned XLEN = 64;
    typedef logic [XLEN-1:0] word_t;
    typedef struct packed {
        word_t val;
        logic  zero;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] ALUctl;
    word_t      A;
    word_t      B;
    logic       out_valid;
    logic       out_ready;
    word_t      ALUout;
    logic       Zero;
    logic       busy;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    riscv_alu_seq #(.XLEN(XLEN)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUctl    (ALUctl),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUout    (ALUout),
        .Zero      (Zero),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a result is consumed when out_valid and out_ready are both high.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got 0x%0h expected no result", ALUout);
                end else begin
                    e = sb.pop_front();
                    chk("result", ALUout, e.val);
                    chk("zero", word_t'(Zero), word_t'(e.zero));
                end
            end
        end
    end

    task automatic issue(input logic [3:0] ctl, input word_t a, input word_t b,
                         input word_t exp, input logic push);
        int n = 0;
        while (!in_ready && n < 500) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1 within 500 cycles");
        end
        ALUctl   = ctl;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        if (push)
            sb.push_back(exp_t'{val: exp, zero: (exp == '0)});
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic bad;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ALUctl    = '0;
        A         = '0;
        B         = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", word_t'(out_valid), 0);
        chk("rst_aluout", ALUout, 0);
        chk("rst_zero", word_t'(Zero), 1);
        chk("rst_busy", word_t'(busy), 0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_in_ready", word_t'(in_ready), 1);

        // Single-cycle operations
        issue(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1);
        chk("add_latency1_valid", word_t'(out_valid), 1);
        chk("add_latency1_value", ALUout, 0);
        issue(4'd0, 64'hF0F0, 64'hFF00, 64'hF000, 1'b1);
        issue(4'd1, 64'hF0F0, 64'h0F0F, 64'hFFFF, 1'b1);
        issue(4'd3, 64'd1, 64'h104, 64'h10, 1'b1);
        issue(4'd4, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b1);
        issue(4'd5, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 1'b1);
        issue(4'd6, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        issue(4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1);
        issue(4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b1);
        issue(4'd9, 64'hFF, 64'h0F, 64'hF0, 1'b1);
        issue(4'd12, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        issue(4'd11, 64'h1234, 64'h5678, 64'd0, 1'b1);
        issue(4'd13, 64'hDEAD_BEEF, 64'h1, 64'd0, 1'b1);
        issue(4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);

        // Back-to-back with out_ready high: no bubble
        issue(4'd2, 64'd1, 64'd2, 64'd3, 1'b1);
        chk("b2b_in_ready", word_t'(in_ready), 1);
        issue(4'd9, 64'hAA, 64'h55, 64'hFF, 1'b1);
        chk("b2b_valid", word_t'(out_valid), 1);
        chk("b2b_value", ALUout, 64'hFF);

        // Backpressure hold
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        issue(4'd2, 64'd2, 64'd3, 64'd5, 1'b1);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ALUout !== 64'd5 || out_valid !== 1'b1 || in_ready !== 1'b0)
                bad = 1'b1;
            @(posedge clock);
            #1;
        end
        chk("hold_10_cycles", word_t'(bad), 0);
        chk("hold_value", ALUout, 64'd5);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("release_clears_valid", word_t'(out_valid), 0);

`ifdef RISCV_ALU_MUL_EN
        issue(4'd10, 64'd7, 64'd6, 64'd42, 1'b1);
        n   = 0;
        bad = 1'b0;
        while (busy && n < 200) begin
            if (in_ready)
                bad = 1'b1;
            n++;
            @(posedge clock);
            #1;
        end
        chk("mul_busy_cycles", word_t'(n), XLEN);
        chk("mul_in_ready_low", word_t'(bad), 0);
        chk("mul_valid", word_t'(out_valid), 1);
        chk("mul_value", ALUout, 64'd42);
        issue(4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);

        // Reset at iteration 20 abandons the multiply
        issue(4'd10, 64'd9, 64'd9, 64'd0, 1'b0);
        repeat (19) @(posedge clock);
        #1;
        chk("mul_busy_mid", word_t'(busy), 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("abort_out_valid", word_t'(out_valid), 0);
        chk("abort_aluout", ALUout, 0);
        chk("abort_busy", word_t'(busy), 0);
        chk("abort_in_ready", word_t'(in_ready), 1);
        bad = 1'b0;
        repeat (80) begin
            @(posedge clock);
            #1;
            if (out_valid || busy)
                bad = 1'b1;
        end
        chk("abort_no_late_result", word_t'(bad), 0);
`else
        issue(4'd10, 64'd7, 64'd6, 64'd0, 1'b1);
        chk("mul_off_busy", word_t'(busy), 0);
        chk("mul_off_valid", word_t'(out_valid), 1);
        chk("mul_off_value", ALUout, 0);
`endif

        issue(4'd6, 64'd100, 64'd58, 64'd42, 1'b1);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        chk("scoreboard_drained", word_t'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
